spm_dual_port: RTL and testbench
================================

# spm_dual_port

Parametrised, dual-ported, byte-writable scratchpad memory for the or1420 data side. Port A serves the CPU load/store path with fixed read latency. Port B serves a DMA/bus agent through a request/grant handshake with a valid strobe on read data. After reset, an initialisation state machine zero-fills the whole array before either port is opened.

## Interface
- DATA_BYTES, default 4: number of 8-bit byte lanes; data width is 8*DATA_BYTES.
- ADDR_BITS, default 11: word address width; depth is 2^ADDR_BITS words.
- READ_LATENCY, default 1: 1 or 2; 2 adds an output register stage on both ports.
- INIT_ON_RESET, default 1: 1 zero-fills the array after reset; 0 skips the fill.
- clock  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- aByteWe  in  DATA_BYTES  port A per-lane write enable.
- aAddress  in  ADDR_BITS  port A word address.
- aDataIn  in  8*DATA_BYTES  port A write data.
- aDataOut  out  8*DATA_BYTES  port A read data.
- bRequest  in  1  port B access request; held until granted.
- bByteWe  in  DATA_BYTES  port B per-lane write enable. All zero means a read.
- bAddress  in  ADDR_BITS  port B word address.
- bDataIn  in  8*DATA_BYTES  port B write data.
- bGrant  out  1  port B request accepted this cycle.
- bDataOut  out  8*DATA_BYTES  port B read data.
- bValid  out  1  bDataOut valid strobe, one cycle per accepted read.
- initBusy  out  1  zero-fill in progress; both ports are closed.

## Operation
- The FSM has two states, INIT and RUN.
  - Reset enters INIT when INIT_ON_RESET=1, otherwise RUN.
  - INIT writes zero to all lanes at the address given by fillCount, then increments fillCount from 0 to 2^ADDR_BITS-1.
  - INIT moves to RUN in the cycle after the last address is written.
  - RUN has no exit other than reset.
- In INIT:
  - Port A writes are ignored.
  - aDataOut holds 0.
  - bGrant stays 0.
  - initBusy = 1.
- Port A in RUN:
  - Every cycle is an access; there is no handshake.
  - Lanes with aByteWe[i]=1 are written.
  - All lanes are read.
  - A read during a same-address write returns the old data (read-before-write).
- Port B in RUN:
  - bGrant = bRequest & ~initBusy, combinational.
  - A transfer happens in any cycle where bRequest and bGrant are both 1.
  - A granted access with bByteWe=0 is a read and produces bValid.
  - A granted access with any lane enabled is a write and produces no bValid.
- Cross-port, same address, same cycle:
  - Per lane, when both ports write, port A wins and port B's lane write is dropped.
  - A read on one port while the other port writes returns the old data.
- Per lane, the zero-fill write overrides every other write.

## Timing
- Reset values:
  - aDataOut = 0, bDataOut = 0, bValid = 0, bGrant = 0.
  - initBusy = INIT_ON_RESET.
  - fillCount = 0.
  - The output pipeline registers are 0.
- Zero-fill takes exactly 2^ADDR_BITS cycles. The first RUN cycle is cycle 2^ADDR_BITS after reset deasserts.
- Read latency on both ports is READ_LATENCY cycles from the address cycle to data.
- bValid rises READ_LATENCY cycles after a granted read. bDataOut holds its value until the next valid read.
- Back-to-back granted reads return one result per cycle in order.
- Reset asserted mid-fill restarts the fill at address 0. Reset does not clear array contents other than through the fill.
- Reset asserted during a port B read in flight kills the pending bValid.

## Structure
- Package spm_pkg holds:
  - the state enum (INIT, RUN);
  - the constant LANE_BITS = 8;
  - the function computing depth from ADDR_BITS.
- Sub-module spm_byte_lane:
  - one 8-bit true dual-port RAM bank with read-before-write and port-A-priority write.
  - The top level instantiates it DATA_BYTES times.
- The top level holds the FSM, the fill counter, the port B handshake and the optional output stage.

## Test plan
- ADDR_BITS=4, INIT_ON_RESET=1: release reset.
  - Required: initBusy high for 16 cycles, then low.
  - Required: port A reads of every address return 0x00000000.
- Port A writes 0xDEADBEEF with aByteWe=4'b0101 to address 3 over a previous value of 0.
  - Required: the next read returns 0x00AD00EF.
  - Required: the same-cycle read returned 0.
- Port B requests a read of address 3 for 3 consecutive cycles.
  - Required: bGrant is 1 each cycle.
  - Required: bValid is 1 for 3 cycles starting READ_LATENCY after the first grant, with data 0x00AD00EF.
- Both ports write address 5 in the same cycle:
  - A: 0x11111111, aByteWe=4'b0011.
  - B: 0x22222222, bByteWe=4'b1111.
  - Required: the read returns 0x22221111.
- Assert reset at fill cycle 7, then release.
  - Required: the fill restarts at 0, initBusy stays high for 16 full cycles, and bGrant stays 0 throughout.
- READ_LATENCY=2: a port A read of address 3.
  - Required: data appears on the second clock edge after the address cycle.
  - Required: bValid timing shifts by one cycle relative to READ_LATENCY=1.

Source files
------------

// File: rtl/spm_pkg.sv
// rtl/spm_pkg.sv - shared types and constants for the dual-port scratchpad
package spm_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } spm_state_e;

    localparam int LANE_BITS = 8;

    function automatic int spm_depth(input int addr_bits);
        return 1 << addr_bits;
    endfunction

endpackage

// File: rtl/spm_byte_lane.sv
// rtl/spm_byte_lane.sv - one 8-bit true dual-port bank, read-before-write, port A write priority
module spm_byte_lane
    import spm_pkg::*;
#(
    parameter int ADDR_BITS = 11
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 a_we,
    input  logic                 a_re,
    input  logic [ADDR_BITS-1:0] a_addr,
    input  logic [LANE_BITS-1:0] a_wdata,
    output logic [LANE_BITS-1:0] a_rdata,
    input  logic                 b_we,
    input  logic                 b_re,
    input  logic [ADDR_BITS-1:0] b_addr,
    input  logic [LANE_BITS-1:0] b_wdata,
    output logic [LANE_BITS-1:0] b_rdata
);

    localparam int DEPTH = spm_depth(ADDR_BITS);

    logic [LANE_BITS-1:0] mem [DEPTH];
    logic [LANE_BITS-1:0] a_rdata_q, a_rdata_d;
    logic [LANE_BITS-1:0] b_rdata_q, b_rdata_d;
    logic                 b_wr_ok;

    // Read registers hold between enabled reads so the top can treat them as held data.
    always_comb begin
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        if (reset) begin
            a_rdata_d = '0;
            b_rdata_d = '0;
        end else begin
            if (a_re) a_rdata_d = mem[a_addr];
            if (b_re) b_rdata_d = mem[b_addr];
        end
        b_wr_ok = b_we && !(a_we && (a_addr == b_addr));
    end

    always_ff @(posedge clock) begin
        a_rdata_q <= a_rdata_d;
        b_rdata_q <= b_rdata_d;
    end

    always_ff @(posedge clock) begin
        if (a_we)    mem[a_addr] <= a_wdata;
        if (b_wr_ok) mem[b_addr] <= b_wdata;
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/spm_dual_port.sv
// rtl/spm_dual_port.sv - byte-writable dual-port scratchpad with zero-fill on reset
module spm_dual_port
    import spm_pkg::*;
#(
    parameter int DATA_BYTES    = 4,
    parameter int ADDR_BITS     = 11,
    parameter int READ_LATENCY  = 1,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [DATA_BYTES-1:0]           aByteWe,
    input  logic [ADDR_BITS-1:0]            aAddress,
    input  logic [LANE_BITS*DATA_BYTES-1:0] aDataIn,
    output logic [LANE_BITS*DATA_BYTES-1:0] aDataOut,
    input  logic                            bRequest,
    input  logic [DATA_BYTES-1:0]           bByteWe,
    input  logic [ADDR_BITS-1:0]            bAddress,
    input  logic [LANE_BITS*DATA_BYTES-1:0] bDataIn,
    output logic                            bGrant,
    output logic [LANE_BITS*DATA_BYTES-1:0] bDataOut,
    output logic                            bValid,
    output logic                            initBusy
);

    localparam int DW = LANE_BITS * DATA_BYTES;

    spm_state_e            state_q, state_d;
    logic [ADDR_BITS-1:0]  fill_count_q, fill_count_d;
    logic                  b_valid1_q, b_valid1_d;
    logic                  init_busy, b_grant, b_rd;
    logic [DATA_BYTES-1:0] lane_a_we, lane_b_we;
    logic [ADDR_BITS-1:0]  lane_a_addr;
    logic [DW-1:0]         lane_a_wdata, lane_a_rdata, lane_b_rdata;

    always_comb begin
        state_d      = state_q;
        fill_count_d = fill_count_q;
        if (state_q == ST_INIT) begin
            fill_count_d = fill_count_q + ADDR_BITS'(1);
            if (fill_count_q == '1) state_d = ST_RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
            fill_count_q <= '0;
            b_valid1_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_count_q <= fill_count_d;
            b_valid1_q   <= b_valid1_d;
        end
    end

    // The fill borrows port A, whose lane priority makes it override any port B write.
    always_comb begin
        init_busy    = (state_q == ST_INIT);
        b_grant      = bRequest & ~init_busy;
        b_rd         = b_grant & ~(|bByteWe);
        b_valid1_d   = b_rd;
        lane_a_we    = init_busy ? '1 : aByteWe;
        lane_a_addr  = init_busy ? fill_count_q : aAddress;
        lane_a_wdata = init_busy ? '0 : aDataIn;
        lane_b_we    = b_grant ? bByteWe : '0;
        if (reset) begin
            lane_a_we = '0;
            lane_b_we = '0;
        end
    end

    for (genvar i = 0; i < DATA_BYTES; i++) begin : g_lane
        spm_byte_lane #(.ADDR_BITS(ADDR_BITS)) u_lane (
            .clock   (clock),
            .reset   (reset),
            .a_we    (lane_a_we[i]),
            .a_re    (~init_busy),
            .a_addr  (lane_a_addr),
            .a_wdata (lane_a_wdata[i*LANE_BITS +: LANE_BITS]),
            .a_rdata (lane_a_rdata[i*LANE_BITS +: LANE_BITS]),
            .b_we    (lane_b_we[i]),
            .b_re    (b_rd),
            .b_addr  (bAddress),
            .b_wdata (bDataIn[i*LANE_BITS +: LANE_BITS]),
            .b_rdata (lane_b_rdata[i*LANE_BITS +: LANE_BITS])
        );
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DW-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
        logic          b_valid2_q, b_valid2_d;

        always_comb begin
            a_out_d    = lane_a_rdata;
            b_out_d    = lane_b_rdata;
            b_valid2_d = b_valid1_q;
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                a_out_q    <= '0;
                b_out_q    <= '0;
                b_valid2_q <= 1'b0;
            end else begin
                a_out_q    <= a_out_d;
                b_out_q    <= b_out_d;
                b_valid2_q <= b_valid2_d;
            end
        end

        assign aDataOut = a_out_q;
        assign bDataOut = b_out_q;
        assign bValid   = b_valid2_q;
    end else begin : g_lat1
        assign aDataOut = lane_a_rdata;
        assign bDataOut = lane_b_rdata;
        assign bValid   = b_valid1_q;
    end

    assign bGrant   = b_grant;
    assign initBusy = init_busy;

endmodule

// File: tb/tb_spm_dual_port.sv
// tb/tb_spm_dual_port.sv - randomized bench for spm_dual_port at read latency 1 and 2
module tb_spm_dual_port;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  aByteWe, bByteWe;
    logic [3:0]  aAddress, bAddress;
    logic [31:0] aDataIn, bDataIn;
    logic        bRequest;
    logic [31:0] a_out1, a_out2, b_out1, b_out2;
    logic        grant1, grant2, valid1, valid2, busy1, busy2;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem_m [16];
    logic [31:0] e_a1, e_a2, e_b1, e_b2;
    logic        e_v1, e_v2;
    int          fill_done;

    always #5 clock = ~clock;

    spm_dual_port #(.DATA_BYTES(4), .ADDR_BITS(4), .READ_LATENCY(1), .INIT_ON_RESET(1)) dut1 (
        .clock(clock), .reset(reset),
        .aByteWe(aByteWe), .aAddress(aAddress), .aDataIn(aDataIn), .aDataOut(a_out1),
        .bRequest(bRequest), .bByteWe(bByteWe), .bAddress(bAddress), .bDataIn(bDataIn),
        .bGrant(grant1), .bDataOut(b_out1), .bValid(valid1), .initBusy(busy1)
    );

    spm_dual_port #(.DATA_BYTES(4), .ADDR_BITS(4), .READ_LATENCY(2), .INIT_ON_RESET(1)) dut2 (
        .clock(clock), .reset(reset),
        .aByteWe(aByteWe), .aAddress(aAddress), .aDataIn(aDataIn), .aDataOut(a_out2),
        .bRequest(bRequest), .bByteWe(bByteWe), .bAddress(bAddress), .bDataIn(bDataIn),
        .bGrant(grant2), .bDataOut(b_out2), .bValid(valid2), .initBusy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of stimulus; the reference model advances from the memory contents it keeps.
    task automatic cycle(input logic rst, input logic [3:0] awe, input logic [3:0] aad,
                         input logic [31:0] adi, input logic breq, input logic [3:0] bwe,
                         input logic [3:0] bad, input logic [31:0] bdi);
        logic        busy, grant, brd;
        logic [31:0] old_a, old_b;
        reset = rst; aByteWe = awe; aAddress = aad; aDataIn = adi;
        bRequest = breq; bByteWe = bwe; bAddress = bad; bDataIn = bdi;
        #2;
        busy  = (fill_done < 16);
        grant = breq && !busy;
        chk("initBusy_l1", {31'd0, busy1}, {31'd0, busy});
        chk("initBusy_l2", {31'd0, busy2}, {31'd0, busy});
        chk("bGrant_l1", {31'd0, grant1}, {31'd0, grant});
        chk("bGrant_l2", {31'd0, grant2}, {31'd0, grant});
        old_a = mem_m[aad];
        old_b = mem_m[bad];
        brd   = grant && (bwe == 4'b0000);
        if (rst) begin
            e_a1 = 0; e_a2 = 0; e_b1 = 0; e_b2 = 0; e_v1 = 0; e_v2 = 0;
            fill_done = 0;
        end else begin
            e_a2 = e_a1; e_b2 = e_b1; e_v2 = e_v1;
            if (!busy) e_a1 = old_a;
            if (brd) e_b1 = old_b;
            e_v1 = brd;
            if (busy) begin
                mem_m[fill_done] = 0;
                fill_done++;
            end else begin
                for (int i = 0; i < 4; i++)
                    if (awe[i]) mem_m[aad][i*8 +: 8] = adi[i*8 +: 8];
                if (grant)
                    for (int i = 0; i < 4; i++)
                        if (bwe[i] && !(awe[i] && aad == bad)) mem_m[bad][i*8 +: 8] = bdi[i*8 +: 8];
            end
        end
        @(posedge clock);
        #1;
        chk("aDataOut_l1", a_out1, e_a1);
        chk("aDataOut_l2", a_out2, e_a2);
        chk("bValid_l1", {31'd0, valid1}, {31'd0, e_v1});
        chk("bValid_l2", {31'd0, valid2}, {31'd0, e_v2});
        chk("bDataOut_l1", b_out1, e_b1);
        chk("bDataOut_l2", b_out2, e_b2);
    endtask

    task automatic idle(input logic [3:0] aad);
        cycle(1'b0, 4'h0, aad, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic rand_cycle(input logic rst);
        logic [3:0] bwe;
        bwe = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        cycle(rst, 4'($urandom_range(0, 2) == 0 ? $urandom : 0), 4'($urandom), $urandom,
              1'($urandom), bwe, 4'($urandom), $urandom);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_m[i] = 0;
        e_a1 = 0; e_a2 = 0; e_b1 = 0; e_b2 = 0; e_v1 = 0; e_v2 = 0; fill_done = 0;
        reset = 1'b1; aByteWe = 0; aAddress = 0; aDataIn = 0;
        bRequest = 0; bByteWe = 0; bAddress = 0; bDataIn = 0;
        repeat (2) @(posedge clock);
        #1;

        // Reset, then a full zero-fill with port A write attempts and port B requests outstanding.
        cycle(1'b1, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
        for (int i = 0; i < 16; i++)
            cycle(1'b0, 4'hf, 4'(i), 32'hFFFF_FFFF, 1'b1, 4'h0, 4'(i), 32'h0);
        for (int i = 0; i < 17; i++) idle(4'(i));

        // Masked write over zero: same-cycle read sees old data.
        cycle(1'b0, 4'b0101, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'h0, 4'h0, 32'h0);
        chk("rbw_same_cycle", a_out1, 32'h0);
        idle(4'd3);
        chk("masked_write", a_out1, 32'h00AD_00EF);

        // Three back-to-back port B reads of address 3.
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd3, 32'h0);
        chk("b_burst_data", b_out1, 32'h00AD_00EF);
        idle(4'd0);
        idle(4'd0);

        // Colliding writes to address 5, then read it back on both ports.
        cycle(1'b0, 4'b0011, 4'd5, 32'h1111_1111, 1'b1, 4'b1111, 4'd5, 32'h2222_2222);
        cycle(1'b0, 4'h0, 4'd5, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0);
        chk("collision_a", a_out1, 32'h2222_1111);
        chk("collision_b", b_out1, 32'h2222_1111);
        idle(4'd0);

        for (int i = 0; i < 300; i++) rand_cycle(1'b0);

        // Reset while a port B read is in flight, then restart the fill at cycle 7.
        cycle(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd9, 32'h0);
        cycle(1'b1, 4'h0, 4'd0, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
        for (int i = 0; i < 7; i++) rand_cycle(1'b0);
        cycle(1'b1, 4'h0, 4'd0, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
        for (int i = 0; i < 16; i++)
            cycle(1'b0, 4'($urandom), 4'($urandom), $urandom, 1'b1, 4'h0, 4'($urandom), 32'h0);
        for (int i = 0; i < 16; i++)
            cycle(1'b0, 4'h0, 4'(i), 32'h0, 1'b1, 4'h0, 4'(15 - i), 32'h0);

        for (int i = 0; i < 200; i++) rand_cycle(1'b0);
        for (int i = 0; i < 100; i++) rand_cycle($urandom_range(0, 40) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
